// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, valid/ready response.
// Optional misaligned-access rejection when DMEM_MISALIGN_CHECK_EN is defined.
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_wr,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_be,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_busy
);

    // state  | meaning
    // S_IDLE | ready for a request
    // S_WAIT | counting wait states, access on cnt==1
    // S_RESP | response held until handshake
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic                r_wr;
    logic [ADDR_W+1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_be;
    logic [31:0]         r_resp_rdata;
    logic                r_resp_err;
    logic [31:0]         r_mem [2**ADDR_W];

    logic                w_accept;
    logic                w_access;
    logic                w_from_req;
    logic                w_acc_wr;
    logic [ADDR_W+1:0]   w_acc_addr;
    logic [31:0]         w_acc_wdata;
    logic [3:0]          w_acc_be;
    logic [ADDR_W-1:0]   w_idx;
    logic                w_misalign;
    logic                w_unused;

    assign w_accept = i_req_valid & o_req_ready;
    assign w_access = ((r_state == S_IDLE) && w_accept && (WAIT_CYCLES == 0)) ||
                      ((r_state == S_WAIT) && (r_cnt == 4'd1));

    // Zero-wait accesses happen on the accept edge, so they use the live request fields.
    assign w_from_req  = (r_state == S_IDLE);
    assign w_acc_wr    = w_from_req ? i_req_wr                  : r_wr;
    assign w_acc_addr  = w_from_req ? i_req_addr[ADDR_W+1:0]    : r_addr;
    assign w_acc_wdata = w_from_req ? i_req_wdata               : r_wdata;
    assign w_acc_be    = w_from_req ? i_req_be                  : r_be;
    assign w_idx       = w_acc_addr[ADDR_W+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_misalign = |w_acc_addr[1:0];
`else
    assign w_misalign = 1'b0;
`endif

    assign w_unused = &{1'b0, i_req_addr[31:ADDR_W+2], w_acc_addr[1:0]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt <= 4'd1) w_next = S_RESP;
            S_RESP:  if (i_resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready  = (r_state == S_IDLE) && !i_rst;
        o_resp_valid = (r_state == S_RESP);
        o_busy       = (r_state != S_IDLE);
        o_resp_rdata = r_resp_rdata;
        o_resp_err   = r_resp_err;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt        <= 4'd0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_be         <= 4'd0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_accept) begin
                r_cnt   <= 4'(WAIT_CYCLES);
                r_wr    <= i_req_wr;
                r_addr  <= i_req_addr[ADDR_W+1:0];
                r_wdata <= i_req_wdata;
                r_be    <= i_req_be;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_resp_rdata <= (w_acc_wr || w_misalign) ? 32'd0 : r_mem[w_idx];
                r_resp_err   <= w_misalign;
            end
        end
    end

    // Array is deliberately not reset; a store dies with reset unless its access edge has passed.
    always_ff @(posedge i_clk) begin
        if (w_access && w_acc_wr && !w_misalign) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_be[i]) r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected responses are queued at request time
// and compared when the responder presents them.
module tb_dmem_responder;

    localparam int ADDR_W      = 10;
    localparam int WAIT_CYCLES = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    resp_t       sb_q[$];
    logic [31:0] model [2**ADDR_W];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_wr     (req_wr),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .i_req_be     (req_be),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_rdata (resp_rdata),
        .o_resp_err   (resp_err),
        .o_busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected outcome is computed from the bench's own word model before the request is driven.
    task automatic run_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int stall, input string tag);
        resp_t exp;
        resp_t got;
        int    idx;
        int    n;
        bit    mis;
        idx = int'(addr[ADDR_W+1:2]);
`ifdef DMEM_MISALIGN_CHECK_EN
        mis = (addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        exp.err = mis;
        if (wr) begin
            exp.rdata = 32'd0;
            if (!mis)
                for (int b = 0; b < 4; b++)
                    if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
        end else begin
            exp.rdata = mis ? 32'd0 : model[idx];
        end
        sb_q.push_back(exp);

        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " accept"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wr    = ~wr;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);

        n = 0;
        while (!resp_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, n, WAIT_CYCLES);

        got.rdata = resp_rdata;
        got.err   = resp_err;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            chk({tag, " stall valid"}, {31'd0, resp_valid}, 32'd1);
            chk({tag, " stall ready"}, {31'd0, req_ready}, 32'd0);
            chk({tag, " stall rdata"}, resp_rdata, got.rdata);
        end

        exp = sb_q.pop_front();
        chk({tag, " rdata"}, got.rdata, exp.rdata);
        chk({tag, " err"}, {31'd0, got.err}, {31'd0, exp.err});

        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({tag, " done valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, " done ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #3;
        chk("rst req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst rdata", resp_rdata, 32'd0);
        chk("rst err", {31'd0, resp_err}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post-rst req_ready", {31'd0, req_ready}, 32'd1);

        run_req(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, "st full");
        run_req(1'b0, 32'h10, 32'h0, 4'b0000, 0, "ld full");
        chk("ld full const", model[4], 32'hDEADBEEF);
        run_req(1'b1, 32'h10, 32'h11223344, 4'b0101, 0, "st be0101");
        run_req(1'b0, 32'h10, 32'h0, 4'b1111, 0, "ld be0101");
        chk("be0101 const", model[4], 32'hDE22BE44);
        run_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, "st be0000");
        run_req(1'b0, 32'h10, 32'h0, 4'b0000, 5, "ld stall");
        run_req(1'b0, 32'h1010, 32'h0, 4'b0000, 0, "ld alias");

        run_req(1'b1, 32'h0, 32'h0BADF00D, 4'b1111, 0, "st w0");
        run_req(1'b1, 32'hFFC, 32'hCAFE1234, 4'b1111, 2, "st wlast");
        run_req(1'b0, 32'h0, 32'h0, 4'b1111, 0, "ld w0");
        run_req(1'b0, 32'hFFC, 32'h0, 4'b1111, 0, "ld wlast");

        // Store of zero killed by reset while still waiting.
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        req_be    = 4'b1111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("wait busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_req(1'b0, 32'h10, 32'h0, 4'b0000, 0, "ld after rst");

        run_req(1'b1, 32'h13, 32'hA5A5A5A5, 4'b1111, 0, "st misalign");
        run_req(1'b0, 32'h10, 32'h0, 4'b0000, 0, "ld misalign");
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("misalign const", model[4], 32'hDE22BE44);
`else
        chk("misalign const", model[4], 32'hA5A5A5A5);
`endif

        chk("sb empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder side of the core's data-memory port: accepts one load/store request at a time over a valid/ready handshake, inserts a configurable number of wait states, performs the access on an internal word array, and returns data and status over a valid/ready response channel. It replaces the zero-latency data memory so the core, or a future multi-cycle core, can be exercised against realistic memory latency and back-pressure.

## Interface
- ADDR_W, 10: word-address bits; the array holds 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2: wait states between accept and access, legal range 0..15.

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_wr  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte enables, bit i selects bits 8i+7:8i
- resp_valid  out  1  response present
- resp_ready  in  1  requester takes the response
- resp_rdata  out  32  load data; 0 for stores
- resp_err  out  1  access rejected
- busy  out  1  request in flight, i.e. state is not IDLE

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On an edge with req_valid&req_ready, latch wr/addr/wdata/be. If WAIT_CYCLES=0, perform the access on that edge and go to RESP. Otherwise load cnt=WAIT_CYCLES and go to WAIT.
- WAIT: req_ready=0. Each edge decrements cnt. On the edge where cnt==1, perform the access and go to RESP.
- RESP: resp_valid=1, with resp_rdata/resp_err held stable until the handshake edge (resp_valid&resp_ready). That edge returns the FSM to IDLE and clears resp_valid.
- Access, word index = latched addr[ADDR_W+1:2]:
  - Upper address bits are ignored; addresses alias modulo 2^(ADDR_W+2) bytes.
  - Store: write only byte lanes with be set. be=4'b0000 leaves memory unchanged but still responds. resp_rdata=0.
  - Load: resp_rdata = full stored word. be is ignored.
- Request fields are sampled only on the accept edge; changes afterwards have no effect.
- Array contents are not reset. Reads of never-written words are undefined.

## Timing
- Reset values: req_ready=0 while rst is high, 1 from the first cycle after release. resp_valid=0, resp_rdata=0, resp_err=0, busy=0. State=IDLE, cnt=0.
- With accept edge E0, resp_valid is first high in the cycle after edge E(max(WAIT_CYCLES,0)), i.e. WAIT_CYCLES edges after accept. For WAIT_CYCLES=0 it is the cycle right after E0.
- The store becomes visible to any later load accepted after the response handshake.
- Throughput: at most one request per WAIT_CYCLES+2 cycles when resp_ready is held high. req_ready is 0 in RESP, so a req_valid held through the response handshake is accepted on the next edge, from IDLE.
- Back-pressure: resp_ready low in RESP holds the state indefinitely with no change to outputs.
- Reset mid-operation: any state goes to IDLE immediately. A store still in WAIT is discarded, and a completed store is kept. The response is lost, and resp_valid drops asynchronously.

## Configuration
- DMEM_MISALIGN_CHECK_EN defined:
  - Requests with latched addr[1:0]!=0 still take the full WAIT latency.
  - The store is suppressed and memory is unchanged.
  - The response carries resp_rdata=0, resp_err=1.
- Undefined: addr[1:0] is ignored, the access proceeds on the aligned word, and resp_err is constant 0.

## Test plan
- Reset, WAIT_CYCLES=2: rst pulse mid-cycle. Required: outputs are reset values at once; req_ready=1 the cycle after release.
- Store/load: store 0xDEADBEEF, be=1111, addr 0x10; then load 0x10. Required: resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 edges after each accept.
- Byte enables: over 0xDEADBEEF, store 0x11223344 with be=0101 at 0x10, then load. Required: 0xDE22BE44. Also store with be=0000, then load. Required: unchanged.
- Back-pressure and aliasing: hold resp_ready=0 for 5 cycles in RESP. Required: resp_valid and resp_rdata stable, req_ready=0. Then load addr 0x10+0x1000 (ADDR_W=10). Required: 0xDE22BE44.
- Reset during WAIT: accept a store of 0x0 to 0x10, assert rst one cycle later, then load 0x10. Required: old value returned.
- Misalign, run both builds: store to 0x13. With the macro: resp_err=1 and memory unchanged. Without the macro: resp_err=0 and word 0x10 updated.
